// File: rtl/nunchuk_pkg.sv
// Shared types and constants for the Wii Nunchuk poller: FSM states, register map, byte-5 layout.
package nunchuk_pkg;

    typedef enum logic [3:0] {
        INIT_F0,
        WAIT_F0,
        INIT_FB,
        WAIT_FB,
        POLL_WAIT,
        PTR,
        WAIT_PTR,
        CONV_WAIT,
        READ,
        WAIT_READ,
        DECODE
    } state_t;

    localparam logic [7:0] REG_INIT1 = 8'hF0;
    localparam logic [7:0] INIT1_VAL = 8'h55;
    localparam logic [7:0] REG_INIT2 = 8'hFB;
    localparam logic [7:0] INIT2_VAL = 8'h00;
    localparam logic [7:0] REG_DATA  = 8'h00;

    // byte 5 packs both buttons (active low) and the accelerometer LSB pairs
    localparam int B5_BTNZ     = 0;
    localparam int B5_BTNC     = 1;
    localparam int B5_ACCX_LSB = 2;
    localparam int B5_ACCY_LSB = 4;
    localparam int B5_ACCZ_LSB = 6;

    function automatic logic is_bus_wait(input state_t s);
        return (s == WAIT_F0) || (s == WAIT_FB) || (s == WAIT_PTR) || (s == WAIT_READ);
    endfunction

endpackage

// File: rtl/nunchuk_timer.sv
// Loadable 32-bit down-counter; tc is high while the count sits at zero.
module nunchuk_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        tc
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 32'd1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/nunchuk_poller.sv
// Sequences the I2C master through Nunchuk init, then polls and decodes 6-byte samples forever.
// state     | meaning
// INIT_F0   | request write 0x55 to 0xF0
// WAIT_F0   | wait for first init write
// INIT_FB   | request write 0x00 to 0xFB
// WAIT_FB   | wait for second init write
// POLL_WAIT | idle between samples
// PTR       | request pointer write to 0x00
// WAIT_PTR  | wait for pointer write
// CONV_WAIT | device conversion time
// READ      | request 6-byte read
// WAIT_READ | wait for read data
// DECODE    | unpack dataOut into outputs
module nunchuk_poller
    import nunchuk_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR       = 8'h52,
    parameter int unsigned POLL_CYCLES    = 100000,
    parameter int unsigned CONV_CYCLES    = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [7:0]      deviceAddr,
    output logic [7:0]      regAddr,
    output logic [2:0]      numBytes,
    output logic [5:0][7:0] dataIn,
    output logic            write,
    output logic            start,
    output logic            driverDisable,
    input  logic [5:0][7:0] dataOut,
    input  logic            done,
    output logic [7:0]      joyX,
    output logic [7:0]      joyY,
    output logic [9:0]      accX,
    output logic [9:0]      accY,
    output logic [9:0]      accZ,
    output logic            btnC,
    output logic            btnZ,
    output logic            sampleValid,
    output logic            initDone,
    output logic            busError
);

    state_t      state;
    logic        bus_wait;
    logic        counting;
    logic        bus_timeout;
    logic        tmr_load;
    logic [31:0] tmr_val;
    logic        tmr_tc;

    assign deviceAddr    = DEV_ADDR;
    assign driverDisable = 1'b0;

    // The timer reloads on every cycle it is not timing, so each wait starts fresh on entry.
    assign bus_wait    = is_bus_wait(state);
    assign counting    = bus_wait || (state == POLL_WAIT) || (state == CONV_WAIT);
    assign tmr_load    = !counting || tmr_tc || (bus_wait && done);
    assign bus_timeout = bus_wait && tmr_tc && !done;
    assign tmr_val     = (state == DECODE || state == WAIT_FB) ? POLL_CYCLES - 32'd1
                       : (state == WAIT_PTR)                   ? CONV_CYCLES - 32'd1
                       :                                         TIMEOUT_CYCLES - 32'd1;

    nunchuk_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= INIT_F0;
            regAddr     <= '0;
            numBytes    <= '0;
            dataIn      <= '0;
            write       <= 1'b0;
            start       <= 1'b0;
            joyX        <= '0;
            joyY        <= '0;
            accX        <= '0;
            accY        <= '0;
            accZ        <= '0;
            btnC        <= 1'b0;
            btnZ        <= 1'b0;
            sampleValid <= 1'b0;
            initDone    <= 1'b0;
            busError    <= 1'b0;
        end else begin
            start       <= 1'b0;
            sampleValid <= 1'b0;
            if (bus_timeout) begin
                busError <= 1'b1;
                initDone <= 1'b0;
                state    <= INIT_F0;
            end else begin
                case (state)
                    INIT_F0: begin
                        regAddr   <= REG_INIT1;
                        numBytes  <= 3'd1;
                        dataIn[0] <= INIT1_VAL;
                        write     <= 1'b1;
                        start     <= 1'b1;
                        state     <= WAIT_F0;
                    end
                    WAIT_F0: if (done) state <= INIT_FB;
                    INIT_FB: begin
                        regAddr   <= REG_INIT2;
                        numBytes  <= 3'd1;
                        dataIn[0] <= INIT2_VAL;
                        write     <= 1'b1;
                        start     <= 1'b1;
                        state     <= WAIT_FB;
                    end
                    WAIT_FB: begin
                        if (done) begin
                            initDone <= 1'b1;
                            state    <= POLL_WAIT;
                        end
                    end
                    POLL_WAIT: if (tmr_tc) state <= PTR;
                    PTR: begin
                        regAddr  <= REG_DATA;
                        numBytes <= 3'd0;
                        write    <= 1'b1;
                        start    <= 1'b1;
                        state    <= WAIT_PTR;
                    end
                    WAIT_PTR: if (done) state <= CONV_WAIT;
                    CONV_WAIT: if (tmr_tc) state <= READ;
                    READ: begin
                        regAddr  <= REG_DATA;
                        numBytes <= 3'd6;
                        write    <= 1'b0;
                        start    <= 1'b1;
                        state    <= WAIT_READ;
                    end
                    WAIT_READ: if (done) state <= DECODE;
                    DECODE: begin
                        joyX        <= dataOut[0];
                        joyY        <= dataOut[1];
                        accX        <= {dataOut[2], dataOut[5][B5_ACCX_LSB +: 2]};
                        accY        <= {dataOut[3], dataOut[5][B5_ACCY_LSB +: 2]};
                        accZ        <= {dataOut[4], dataOut[5][B5_ACCZ_LSB +: 2]};
                        btnZ        <= ~dataOut[5][B5_BTNZ];
                        btnC        <= ~dataOut[5][B5_BTNC];
                        sampleValid <= 1'b1;
                        state       <= POLL_WAIT;
                    end
                    default: state <= INIT_F0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nunchuk_poller.sv
// Bench for nunchuk_poller: bench-side master model answers requests, decoded samples checked against an arithmetic model.
module tb_nunchuk_poller;

    localparam int P     = 10;
    localparam int C     = 5;
    localparam int T     = 50;
    localparam int LIMIT = 400;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [7:0]      deviceAddr, regAddr;
    logic [2:0]      numBytes;
    logic [5:0][7:0] dataIn;
    logic [5:0][7:0] dataOut;
    logic            write, start, driverDisable, done;
    logic [7:0]      joyX, joyY;
    logic [9:0]      accX, accY, accZ;
    logic            btnC, btnZ, sampleValid, initDone, busError;

    int         checks  = 0;
    int         errors  = 0;
    int         cyc     = 0;
    int         t_ref   = 0;
    int         gap_exp = 0;
    logic [7:0] bytes [6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nunchuk_poller #(
        .DEV_ADDR       (8'h52),
        .POLL_CYCLES    (P),
        .CONV_CYCLES    (C),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .deviceAddr    (deviceAddr),
        .regAddr       (regAddr),
        .numBytes      (numBytes),
        .dataIn        (dataIn),
        .write         (write),
        .start         (start),
        .driverDisable (driverDisable),
        .dataOut       (dataOut),
        .done          (done),
        .joyX          (joyX),
        .joyY          (joyY),
        .accX          (accX),
        .accY          (accY),
        .accZ          (accZ),
        .btnC          (btnC),
        .btnZ          (btnZ),
        .sampleValid   (sampleValid),
        .initDone      (initDone),
        .busError      (busError)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input string tag, output int t);
        bit got;
        got = 1'b0;
        t = 0;
        for (int i = 0; i < LIMIT && !got; i++) begin
            @(negedge clk);
            if (start) begin
                got = 1'b1;
                t = cyc;
            end
        end
        check({tag, "_start_seen"}, int'(got), 1);
    endtask

    // Master model: done is seen by the DUT in cycle t_start + d.
    task automatic serve(input string tag, input int t_start, input int d, output int t_done);
        @(negedge clk);
        check({tag, "_start_width"}, int'(start), 0);
        while (cyc < t_start + d) @(negedge clk);
        done = 1'b1;
        t_done = cyc;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic check_req(input string tag, input int ra, input int nb, input int wr);
        check({tag, "_regAddr"}, int'(regAddr), ra);
        check({tag, "_numBytes"}, int'(numBytes), nb);
        check({tag, "_write"}, int'(write), wr);
        check({tag, "_devAddr"}, int'(deviceAddr), 'h52);
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_req"}, int'({regAddr, numBytes, write, start, driverDisable}), 0);
        check({tag, "_dataIn"}, int'(dataIn != '0), 0);
        check({tag, "_joy_btn"}, int'({joyX, joyY, btnC, btnZ}), 0);
        check({tag, "_acc"}, int'({accX, accY, accZ}), 0);
        check({tag, "_flags"}, int'({sampleValid, initDone, busError}), 0);
        check({tag, "_devAddr"}, int'(deviceAddr), 'h52);
    endtask

    task automatic check_outputs(input string tag, input int jx, input int jy, input int ax,
                                 input int ay, input int az, input int bc, input int bz);
        check({tag, "_joyX"}, int'(joyX), jx);
        check({tag, "_joyY"}, int'(joyY), jy);
        check({tag, "_accX"}, int'(accX), ax);
        check({tag, "_accY"}, int'(accY), ay);
        check({tag, "_accZ"}, int'(accZ), az);
        check({tag, "_btnC"}, int'(btnC), bc);
        check({tag, "_btnZ"}, int'(btnZ), bz);
    endtask

    // pre >= 0 means the first start was already observed at that cycle.
    task automatic do_init(input int d, input int pre);
        int s, td;
        if (pre >= 0) s = pre;
        else wait_start("init1", s);
        check_req("init1", 'hF0, 1, 1);
        check("init1_data", int'(dataIn[0]), 'h55);
        serve("init1", s, d, td);
        wait_start("init2", s);
        // done cycle, then INIT_FB, then start
        check("init2_gap", s - td, 2);
        check_req("init2", 'hFB, 1, 1);
        check("init2_data", int'(dataIn[0]), 'h00);
        check("init2_initDone_low", int'(initDone), 0);
        serve("init2", s, d, td);
        check("init_done", int'(initDone), 1);
        t_ref = td;
        gap_exp = P + 2;
    endtask

    // Poll one sample; fixed_vec compares against the hand-computed reference vector.
    task automatic do_poll(input string tag, input int d1, input int d2, input bit stray, input bit fixed_vec);
        int s, td, tr, b5;
        wait_start({tag, "_ptr"}, s);
        check({tag, "_ptr_gap"}, s - t_ref, gap_exp);
        check_req({tag, "_ptr"}, 'h00, 0, 1);
        serve({tag, "_ptr"}, s, d1, td);
        wait_start({tag, "_read"}, s);
        // done cycle, CONV_WAIT for C cycles, READ, then start
        check({tag, "_read_gap"}, s - td, C + 2);
        check_req({tag, "_read"}, 'h00, 6, 0);
        for (int i = 0; i < 6; i++) dataOut[i] = bytes[i];
        serve({tag, "_read"}, s, d2, tr);
        check({tag, "_sv_early"}, int'(sampleValid), 0);
        @(negedge clk);
        check({tag, "_sv_pulse"}, int'(sampleValid), 1);
        if (fixed_vec) begin
            check_outputs(tag, 'h80, 'h7F, 'h297, 'h169, 'h3FE, 0, 1);
        end else begin
            b5 = int'(bytes[5]);
            check_outputs(tag, int'(bytes[0]), int'(bytes[1]),
                          int'(bytes[2]) * 4 + (b5 / 4) % 4,
                          int'(bytes[3]) * 4 + (b5 / 16) % 4,
                          int'(bytes[4]) * 4 + b5 / 64,
                          ((b5 / 2) % 2 == 0) ? 1 : 0,
                          (b5 % 2 == 0) ? 1 : 0);
        end
        @(negedge clk);
        check({tag, "_sv_single"}, int'(sampleValid), 0);
        if (stray) begin
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
        end
        // read done cycle, DECODE, POLL_WAIT for P cycles, PTR, then start
        t_ref = tr;
        gap_exp = P + 3;
    endtask

    initial begin
        int s, td, prev_jx;
        done = 1'b0;
        dataOut = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_state("reset");
        rst = 1'b1;

        do_init(20, -1);

        bytes = '{8'h80, 8'h7F, 8'hA5, 8'h5A, 8'hFF, 8'b10_01_11_10};
        do_poll("fixed", 20, 20, 1'b0, 1'b1);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
            do_poll("rand", int'($urandom_range(1, 40)), int'($urandom_range(1, 40)), k == 1, 1'b0);
        end

        // done lands on the timeout terminal-count cycle of both waits
        for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
        do_poll("coinc", T - 1, T - 1, 1'b0, 1'b0);
        check("coinc_busError", int'(busError), 0);
        prev_jx = int'(bytes[0]);

        // read never answered
        wait_start("to_ptr", s);
        serve("to_ptr", s, 20, td);
        wait_start("to_read", s);
        while (cyc < s + T - 1) @(negedge clk);
        check("to_before_busError", int'(busError), 0);
        check("to_before_initDone", int'(initDone), 1);
        @(negedge clk);
        check("to_busError", int'(busError), 1);
        check("to_initDone", int'(initDone), 0);
        check("to_joyX_hold", int'(joyX), prev_jx);
        @(negedge clk);
        check("to_restart_start", int'(start), 1);
        do_init(20, cyc);
        check("to_busError_sticky", int'(busError), 1);

        // reset during WAIT_READ
        wait_start("rst_ptr", s);
        serve("rst_ptr", s, 20, td);
        wait_start("rst_read", s);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check_zero_state("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_init(20, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
